// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner: FSM state encoding,
// width calculation for derived parameters and the linear key-code mapping.
package keypad_pkg;

  // Scanner FSM states.
  typedef enum logic [1:0] {
    KP_SCAN     = 2'd0,
    KP_DEBOUNCE = 2'd1,
    KP_HELD     = 2'd2,
    KP_RELEASE  = 2'd3
  } kp_state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int kp_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Linear key code: row index major, column index minor.
  function automatic int kp_code(input int row_idx, input int col_idx, input int cols);
    return row_idx * cols + col_idx;
  endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Small synchronous key-event FIFO with registered head, occupancy count,
// and a one-cycle drop pulse when a push is refused because the queue is full.
module keypad_fifo
  import keypad_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW   = kp_width(DEPTH),
  localparam int CNTW = kp_width(DEPTH + 1)
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CNTW-1:0]  count,
  output logic             full,
  output logic             drop
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  assign valid = (count_q != '0);
  assign full  = (count_q == CNTW'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_q];

  // Decide which of push/pop take effect; a pop on an empty queue is ignored,
  // a push on a full queue only succeeds when a pop frees a slot the same cycle.
  always_comb begin
    pop_ok  = pop && valid;
    push_ok = push && (!full || pop_ok);
    drop    = push && full && !pop_ok;
    rd_d    = pop_ok  ? rd_q + 1'b1 : rd_q;
    wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage array, cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_q] <= din;
    end
  end

endmodule

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: walks a one-cold column drive on a slow tick,
// debounces presses and releases, and queues one code per accepted press.
//
// Consumer handshake: key_valid is high while the queue is non-empty and
// key_code shows the oldest event; a cycle with key_ack high while key_valid
// is high pops that event. key_ack while key_valid is low has no effect.
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = kp_width(ROWS * COLS),
  localparam int NW        = kp_width(FIFO_DEPTH + 1)
) (
  input  logic            clk1,
  input  logic            reset,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] column,
  output logic            key_valid,
  output logic [CW-1:0]   key_code,
  input  logic            key_ack,
  output logic            interrupt,
  output logic            overflow,
  output logic [NW-1:0]   fifo_count
);

  localparam int PW  = kp_width(SCAN_DIV);
  localparam int CIW = kp_width(COLS);
  localparam int RIW = kp_width(ROWS);
  localparam int DW  = kp_width(DEBOUNCE);

  localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [CIW-1:0] COL_LAST   = CIW'(COLS - 1);
  localparam logic [DW-1:0]  DB_LAST    = DW'(DEBOUNCE - 1);

  logic [PW-1:0]   presc_q, presc_d;
  logic            tick;
  kp_state_e       state_q, state_d;
  logic [CIW-1:0]  col_q, col_d;
  logic [CIW-1:0]  col_next;
  logic [ROWS-1:0] row_lat_q, row_lat_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic            pressed;
  logic [RIW-1:0]  lat_row_idx;
  logic            push;
  logic [CW-1:0]   push_code;
  logic            pop_ok;
  logic            fifo_drop;
  logic            unused_fifo_full;
  logic            overflow_q, overflow_d;
  logic            interrupt_q;

  // Scan prescaler: tick marks the last cycle of each SCAN_DIV period.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // Row decode: any low row means a key is down in the driven column;
  // the lowest low row of the latched pattern names the key.
  always_comb begin
    pressed     = (row != '1);
    lat_row_idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!row_lat_q[i]) begin
        lat_row_idx = RIW'(i);
      end
    end
    push_code = CW'(kp_code(int'(lat_row_idx), int'(col_q), COLS));
    col_next  = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
  end

  // One-cold column drive from the current column index.
  always_comb begin
    for (int i = 0; i < COLS; i++) begin
      column[i] = (col_q != CIW'(i));
    end
  end

  // Scanner FSM: all decisions are taken on tick only.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_lat_d = row_lat_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    if (tick) begin
      case (state_q)
        KP_SCAN: begin
          if (pressed) begin
            row_lat_d = row;
            cnt_d     = '0;
            state_d   = KP_DEBOUNCE;
          end else begin
            col_d = col_next;
          end
        end
        KP_DEBOUNCE: begin
          if (row == row_lat_q) begin
            if (cnt_q == DB_LAST) begin
              push    = 1'b1;
              state_d = KP_HELD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            // Bounce: abandon the candidate but stay on this column.
            state_d = KP_SCAN;
          end
        end
        KP_HELD: begin
          if (!pressed) begin
            cnt_d   = '0;
            state_d = KP_RELEASE;
          end
        end
        KP_RELEASE: begin
          if (pressed) begin
            state_d = KP_HELD;
          end else if (cnt_q == DB_LAST) begin
            col_d   = col_next;
            state_d = KP_SCAN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = KP_SCAN;
      endcase
    end
  end

  // Scanner and prescaler state registers.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      state_q   <= KP_SCAN;
      col_q     <= '0;
      row_lat_q <= '1;
      cnt_q     <= '0;
    end else begin
      presc_q   <= presc_d;
      state_q   <= state_d;
      col_q     <= col_d;
      row_lat_q <= row_lat_d;
      cnt_q     <= cnt_d;
    end
  end

  keypad_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk1  (clk1),
    .reset (reset),
    .push  (push),
    .din   (push_code),
    .pop   (key_ack),
    .dout  (key_code),
    .valid (key_valid),
    .count (fifo_count),
    .full  (unused_fifo_full),
    .drop  (fifo_drop)
  );

  // Sticky overflow: set by a refused push, cleared by the next real pop.
  // A drop implies no pop that cycle, so the two never coincide.
  always_comb begin
    pop_ok     = key_ack && key_valid;
    overflow_d = overflow_q;
    if (fifo_drop) begin
      overflow_d = 1'b1;
    end else if (pop_ok) begin
      overflow_d = 1'b0;
    end
  end

  // Overflow flag and the one-cycle-delayed interrupt copy of key_valid.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      interrupt_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      interrupt_q <= key_valid;
    end
  end

  assign overflow  = overflow_q;
  assign interrupt = interrupt_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo (4x4, SCAN_DIV=2, DEBOUNCE=3, depth 4).
// Stimulus pushes hand-computed key codes into exp_q; a monitor pops and
// compares on every accepted key_ack.
module tb_keypad_scan_fifo;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int SCAN_DIV   = 2;
  localparam int DEBOUNCE   = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int CW         = 4;
  localparam int NW         = 3;

  logic            clk1 = 1'b0;
  logic            reset = 1'b0;
  logic [ROWS-1:0] row = '1;
  logic [COLS-1:0] column;
  logic            key_valid;
  logic [CW-1:0]   key_code;
  logic            key_ack = 1'b0;
  logic            interrupt;
  logic            overflow;
  logic [NW-1:0]   fifo_count;

  logic [CW-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  keypad_scan_fifo #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .SCAN_DIV   (SCAN_DIV),
    .DEBOUNCE   (DEBOUNCE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk1       (clk1),
    .reset      (reset),
    .row        (row),
    .column     (column),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ack    (key_ack),
    .interrupt  (interrupt),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  // Clock
  always #5 clk1 = ~clk1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Wait for the column drive to switch into column c (always on a scan tick).
  task automatic wait_col_enter(input int c);
    logic [3:0] one;
    logic [3:0] tgt;
    logic [3:0] prev;
    bit         hit;
    one  = 4'b0001;
    tgt  = ~(one << c);
    prev = column;
    hit  = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk1);
      if (column == tgt && prev != tgt) hit = 1'b1;
      prev = column;
    end
    if (!hit) begin
      n_vec++;
      n_miss++;
      $display("FAIL wait_col%0d: column %b never switched to %b within 200 cycles", c, column, tgt);
    end
  endtask

  task automatic ack_pulse();
    @(posedge clk1);
    #1 key_ack = 1'b1;
    @(posedge clk1);
    #1 key_ack = 1'b0;
  endtask

  // Press a key in column c, hold for 'hold' cycles, release and let the FSM settle.
  task automatic press(input int c, input logic [3:0] pat, input int hold);
    wait_col_enter(c);
    row = pat;
    repeat (hold) @(negedge clk1);
    row = 4'hF;
    repeat (10) @(negedge clk1);
  endtask

  // Scoreboard monitor: every accepted pop is compared with the oldest expected code.
  always @(negedge clk1) begin
    if (key_ack && key_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_pop: got code %0d, expected no event", key_code);
      end else begin
        check("pop_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  // Watchdog
  initial begin
    #300000;
    n_vec++;
    n_miss++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    // Reset state
    #1 reset = 1'b1;
    #1;
    check("rst_column", column, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_irq", interrupt, 0);
    check("rst_ovf", overflow, 0);
    check("rst_count", fifo_count, 0);
    repeat (3) @(negedge clk1);
    reset = 1'b0;

    // Single press: col 1, row 2 -> code 9
    wait_col_enter(1);
    row = 4'b1011;
    exp_q.push_back(4'd9);
    repeat (7) @(negedge clk1);
    check("t1_valid_early", key_valid, 0);
    @(negedge clk1);
    check("t1_valid", key_valid, 1);
    check("t1_code", key_code, 9);
    check("t1_irq_lag", interrupt, 0);
    @(negedge clk1);
    check("t1_irq", interrupt, 1);
    repeat (13) @(negedge clk1);
    row = 4'hF;
    repeat (12) @(negedge clk1);
    check("t1_no_repeat", fifo_count, 1);
    ack_pulse();
    @(negedge clk1);
    check("t1_count_after_pop", fifo_count, 0);
    check("t1_valid_after_pop", key_valid, 0);
    check("t1_irq_hold", interrupt, 1);
    @(negedge clk1);
    check("t1_irq_clear", interrupt, 0);

    // Bounce: two low ticks, no event, column holds one extra tick
    wait_col_enter(2);
    row = 4'b0111;
    repeat (5) @(negedge clk1);
    row = 4'hF;
    @(negedge clk1);
    check("t2_col_hold_a", column, 4'b1011);
    @(negedge clk1);
    check("t2_col_hold_b", column, 4'b1011);
    @(negedge clk1);
    check("t2_col_adv", column, 4'b0111);
    check("t2_count", fifo_count, 0);

    // Held key: col 0, row 0 -> code 0, no auto-repeat, 1-tick release bounce
    wait_col_enter(0);
    row = 4'b1110;
    exp_q.push_back(4'd0);
    repeat (100) @(negedge clk1);
    check("t3_count", fifo_count, 1);
    check("t3_col", column, 4'b1110);
    check("t3_valid", key_valid, 1);
    row = 4'hF;
    repeat (2) @(negedge clk1);
    row = 4'b1110;
    repeat (10) @(negedge clk1);
    check("t3_bounce_count", fifo_count, 1);
    check("t3_bounce_col", column, 4'b1110);
    row = 4'hF;
    repeat (12) @(negedge clk1);
    ack_pulse();
    @(negedge clk1);
    check("t3_count_after_pop", fifo_count, 0);

    // Overflow: five presses, no ack; fifth is dropped
    press(1, 4'b1110, 12); exp_q.push_back(4'd1);
    press(2, 4'b1101, 12); exp_q.push_back(4'd6);
    press(3, 4'b1011, 12); exp_q.push_back(4'd11);
    press(0, 4'b0111, 12); exp_q.push_back(4'd12);
    check("t4_ovf_before", overflow, 0);
    press(1, 4'b1101, 12);
    check("t4_count", fifo_count, 4);
    check("t4_ovf", overflow, 1);
    check("t4_head", key_code, 1);
    ack_pulse();
    @(negedge clk1);
    check("t4_ovf_clear", overflow, 0);
    check("t4_count_after_pop", fifo_count, 3);
    check("t4_head_after_pop", key_code, 6);

    // Full plus simultaneous ack on the push cycle
    press(2, 4'b1110, 12); exp_q.push_back(4'd2);
    check("t5_full", fifo_count, 4);
    wait_col_enter(3);
    row = 4'b0111;
    exp_q.push_back(4'd15);
    repeat (7) @(posedge clk1);
    #1 key_ack = 1'b1;
    @(posedge clk1);
    #1 key_ack = 1'b0;
    @(negedge clk1);
    check("t5_count", fifo_count, 4);
    check("t5_ovf", overflow, 0);
    check("t5_head", key_code, 11);
    repeat (4) @(negedge clk1);
    row = 4'hF;
    repeat (12) @(negedge clk1);
    repeat (4) ack_pulse();
    @(negedge clk1);
    check("t5_drained", fifo_count, 0);

    // Reset mid-DEBOUNCE with one event already queued
    press(0, 4'b1011, 12); exp_q.push_back(4'd8);
    check("t6_pre_valid", key_valid, 1);
    wait_col_enter(1);
    row = 4'b1101;
    repeat (4) @(negedge clk1);
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    check("t6_column", column, 4'b1110);
    check("t6_valid", key_valid, 0);
    check("t6_code", key_code, 0);
    check("t6_count", fifo_count, 0);
    check("t6_irq", interrupt, 0);
    check("t6_ovf", overflow, 0);
    row = 4'hF;
    repeat (3) @(negedge clk1);
    reset = 1'b0;
    repeat (20) @(negedge clk1);
    check("t6_no_ghost_count", fifo_count, 0);
    check("t6_no_ghost_valid", key_valid, 0);
    wait_col_enter(1);
    row = 4'b1101;
    exp_q.push_back(4'd5);
    repeat (8) @(negedge clk1);
    check("t6_fresh_valid", key_valid, 1);
    check("t6_fresh_code", key_code, 5);
    row = 4'hF;
    repeat (10) @(negedge clk1);
    ack_pulse();
    @(negedge clk1);
    check("t6_final_count", fifo_count, 0);

    // Every expected event must have been popped
    check("end_exp_empty", exp_q.size(), 0);
    check("end_valid", key_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
